ram_bist_ctrl: RTL

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_pkg.sv | 8 +
 rtl/ram_bist_ctrl_if.sv | 11 +
 rtl/ram_bist_cmp.sv | 49 ++++
 rtl/ram_bist_ctrl.sv | 80 ++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and FSM encoding for the RAM BIST controller
package ram_pkg;
  localparam int DATA_WIDTH_D = 8;
  localparam int DEPTH_D = 16;
  localparam int ADDR_W_D = 4;
  localparam int RD_LAT_D = 1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if: RAM bus between the BIST controller (master) and the RAM (slave)
interface ram_bist_ctrl_if #(parameter int DATA_WIDTH = 8, parameter int ADDR_W = 4);
  logic ram_cs;
  logic ram_wr_en;
  logic ram_out_en;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_address_in;
  logic [DATA_WIDTH-1:0] ram_data_out;
  modport master(output ram_cs, ram_wr_en, ram_out_en, ram_data_in, ram_address_in, input ram_data_out);
  modport slave(input ram_cs, ram_wr_en, ram_out_en, ram_data_in, ram_address_in, output ram_data_out);
endinterface

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: aligns expected data/address with RAM read latency and counts mismatches
module ram_bist_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic vld,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_W:0] err_count,
  output logic [ADDR_W-1:0] fail_addr
);
  logic [RD_LAT-1:0] vld_d;
  logic [DATA_WIDTH-1:0] data_d [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];
  logic miss;
  assign miss = vld_d[RD_LAT-1] && (rdata != data_d[RD_LAT-1]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_d[i] <= '0;
        addr_d[i] <= '0;
      end
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_d[i] <= vld_d[i-1];
        data_d[i] <= data_d[i-1];
        addr_d[i] <= addr_d[i-1];
      end
      vld_d[0] <= vld;
      data_d[0] <= exp_data;
      addr_d[0] <= exp_addr;
      if (clr) begin
        err_count <= '0;
        fail_addr <= '0;
      end else if (miss) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) fail_addr <= addr_d[RD_LAT-1];
      end
    end
  end
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write-then-read-back RAM self test with seeded address-XOR pattern
module ram_bist_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int RD_LAT = RD_LAT_D
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [ADDR_W:0] err_count,
  output logic [ADDR_W-1:0] fail_addr,
  ram_bist_ctrl_if.master ram
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] seed_q, exp_data;
  logic pass_q, last, accept;
  assign last = cnt == ADDR_W'(DEPTH - 1);
  assign accept = state == IDLE && start;
  assign exp_data = DATA_WIDTH'(cnt) ^ seed_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      seed_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) seed_q <= seed;
      pass_q <= accept ? 1'b0 : state == DONE ? err_count == '0 : pass_q;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = WRITE;
      end
      WRITE: if (last) state_n = READ;
      READ: if (last) state_n = DRAIN;
      DRAIN: if (cnt == ADDR_W'(RD_LAT - 1)) begin
        state_n = DONE;
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  assign ram.ram_cs = state == WRITE || state == READ;
  assign ram.ram_wr_en = state == WRITE;
  assign ram.ram_out_en = state == READ;
  assign ram.ram_data_in = state == WRITE ? exp_data : '0;
  assign ram.ram_address_in = ram.ram_cs ? cnt : '0;
  assign busy = state == WRITE || state == READ || state == DRAIN;
  assign done = state == DONE;
  assign pass = done ? err_count == '0 : pass_q;
  ram_bist_cmp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_cmp (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .vld(state == READ),
    .exp_data(exp_data),
    .exp_addr(cnt),
    .rdata(ram.ram_data_out),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );
endmodule
